// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 32-bit carry-lookahead adder, with a registered
// response slot per requester. Define ADDER_ARB_RR_EN for round-robin conflict resolution.

module adder_arbiter_cla (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum
);
  logic [31:0] w_g, w_p, w_c;
  logic [7:0]  w_gg, w_gp;
  logic [8:0]  w_gc;
  logic        w_bc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // 4-bit groups: group generate/propagate first, then lookahead across groups,
  // then the bit carries inside each group from its group carry-in.
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    w_bc = 1'b0;
    w_gc[0] = i_cin;
    for (int k = 0; k < 8; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
      w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      w_bc = w_gc[k];
      for (int j = 0; j < 4; j++) begin
        w_c[4*k+j] = w_bc;
        w_bc = w_g[4*k+j] | (w_p[4*k+j] & w_bc);
      end
    end
  end

  assign o_sum = w_p ^ w_c;
endmodule

module adder_arbiter_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_ready,
  input  logic [31:0] i_sum,
  input  logic        i_ovf,
  output logic        o_valid,
  output logic [31:0] o_sum,
  output logic        o_ovf
);
  logic        r_valid;
  logic [31:0] r_sum;
  logic        r_ovf;

  // A load wins over a drain so a consumed slot refills without a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_sum   <= i_sum;
      r_ovf   <= i_ovf;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_ovf   = r_ovf;
endmodule

module adder_arbiter #(
  parameter bit PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_sum,
  output logic        rsp0_ovf,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_sum,
  output logic        rsp1_ovf,
  output logic        grant_id
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0][31:0] w_req_a, w_req_b, w_rsp_sum;
  logic [NUM_REQ-1:0]       w_req_valid, w_req_sub;
  logic [NUM_REQ-1:0]       w_rsp_valid, w_rsp_ready, w_rsp_ovf;
  logic [NUM_REQ-1:0]       w_elig, w_gnt;
  logic                     w_sel;
  logic [31:0]              w_a, w_b, w_sum;
  logic                     w_cin, w_ovf;
  logic                     r_grant_id;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_req_a     = {req1_a, req0_a};
  assign w_req_b     = {req1_b, req0_b};
  assign w_req_sub   = {req1_sub, req0_sub};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  assign w_elig = w_req_valid & (~w_rsp_valid | w_rsp_ready);

  always_comb begin
    w_gnt = '0;
    if (!reset) begin
      if (&w_elig) begin
`ifdef ADDER_ARB_RR_EN
        w_gnt = r_grant_id ? 2'b01 : 2'b10;
`else
        w_gnt = (PRIO == 1'b0) ? 2'b01 : 2'b10;
`endif
      end else begin
        w_gnt = w_elig;
      end
    end
  end

  // Operand mux and adder configuration for the single winner.
  assign w_sel = w_gnt[1];
  assign w_a   = w_req_a[w_sel];
  assign w_b   = w_req_sub[w_sel] ? ~w_req_b[w_sel] : w_req_b[w_sel];
  assign w_cin = w_req_sub[w_sel];

  adder_arbiter_cla u_cla (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_cin (w_cin),
    .o_sum (w_sum)
  );

  assign w_ovf = (w_a[31] == w_b[31]) && (w_sum[31] != w_b[31]);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    adder_arbiter_slot u_slot (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_gnt[i]),
      .i_ready (w_rsp_ready[i]),
      .i_sum   (w_sum),
      .i_ovf   (w_ovf),
      .o_valid (w_rsp_valid[i]),
      .o_sum   (w_rsp_sum[i]),
      .o_ovf   (w_rsp_ovf[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset)       r_grant_id <= 1'b1;
    else if (|w_gnt) r_grant_id <= w_gnt[1];
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp0_sum   = w_rsp_sum[0];
  assign rsp1_sum   = w_rsp_sum[1];
  assign rsp0_ovf   = w_rsp_ovf[0];
  assign rsp1_ovf   = w_rsp_ovf[1];
  assign grant_id   = r_grant_id;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter; conflict expectations follow ADDER_ARB_RR_EN.

module tb_adder_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_ovf;
  logic [31:0] rsp0_sum;
  logic        rsp1_valid, rsp1_ready, rsp1_ovf;
  logic [31:0] rsp1_sum;
  logic        grant_id;

  int n_vec = 0;
  int n_err = 0;

  adder_arbiter #(.PRIO(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_ovf(rsp1_ovf),
    .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
  endtask

  initial begin
    logic rr;
    logic win;
`ifdef ADDER_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    reset = 1'b1;
    set0(1'b1, 32'd1, 32'd1, 1'b0);
    set1(1'b1, 32'd1, 32'd1, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    tick(); tick();
    chk("rst_v0", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_v1", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_s0", rsp0_sum, 32'd0);
    chk("rst_s1", rsp1_sum, 32'd0);
    chk("rst_o0", {31'd0, rsp0_ovf}, 32'd0);
    chk("rst_gid", {31'd0, grant_id}, 32'd1);

    // simple add on requester 0
    reset = 1'b0;
    set0(1'b1, 32'd5, 32'd7, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("add_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    chk("add_v0", {31'd0, rsp0_valid}, 32'd1);
    chk("add_s0", rsp0_sum, 32'd12);
    chk("add_o0", {31'd0, rsp0_ovf}, 32'd0);
    chk("add_gid", {31'd0, grant_id}, 32'd0);
    set0(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    chk("drain_v0", {31'd0, rsp0_valid}, 32'd0);

    // overflow / wrap vectors on requester 1, back to back
    set1(1'b1, 32'h8000_0000, 32'd1, 1'b1); tick();
    chk("subovf_s", rsp1_sum, 32'h7FFF_FFFF);
    chk("subovf_o", {31'd0, rsp1_ovf}, 32'd1);
    set1(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0); tick();
    chk("addovf_s", rsp1_sum, 32'h8000_0000);
    chk("addovf_o", {31'd0, rsp1_ovf}, 32'd1);
    set1(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0); tick();
    chk("wrap_s", rsp1_sum, 32'd0);
    chk("wrap_o", {31'd0, rsp1_ovf}, 32'd0);
    set1(1'b1, 32'd3, 32'd5, 1'b1); tick();
    chk("neg_s", rsp1_sum, 32'hFFFF_FFFE);
    chk("neg_o", {31'd0, rsp1_ovf}, 32'd0);
    chk("neg_gid", {31'd0, grant_id}, 32'd1);

    // conflict for 4 cycles, grant_id starts at 1
    for (int k = 0; k < 4; k++) begin
      set0(1'b1, k, 32'd10, 1'b0);
      set1(1'b1, 32'd100 + k, 32'd1, 1'b1);
      win = rr ? k[0] : 1'b0;
      #1;
      chk($sformatf("cf%0d_rdy0", k), {31'd0, req0_ready}, {31'd0, ~win});
      chk($sformatf("cf%0d_rdy1", k), {31'd0, req1_ready}, {31'd0, win});
      tick();
      chk($sformatf("cf%0d_gid", k), {31'd0, grant_id}, {31'd0, win});
      if (win) chk($sformatf("cf%0d_s1", k), rsp1_sum, 32'd99 + k);
      else     chk($sformatf("cf%0d_s0", k), rsp0_sum, 32'd10 + k);
    end
    set0(1'b0, 32'd0, 32'd0, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0);
    tick();

    // backpressure on slot 0 while requester 1 streams
    rsp0_ready = 1'b0;
    set0(1'b1, 32'd20, 32'd22, 1'b0); tick();
    chk("bp_load_s0", rsp0_sum, 32'd42);
    for (int k = 0; k < 3; k++) begin
      set0(1'b1, 32'd99, 32'd1, 1'b0);
      set1(1'b1, 32'd200 + k, 32'd2, 1'b0);
      #1;
      chk($sformatf("bp%0d_rdy0", k), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp%0d_rdy1", k), {31'd0, req1_ready}, 32'd1);
      tick();
      chk($sformatf("bp%0d_s0", k), rsp0_sum, 32'd42);
      chk($sformatf("bp%0d_v0", k), {31'd0, rsp0_valid}, 32'd1);
      chk($sformatf("bp%0d_s1", k), rsp1_sum, 32'd202 + k);
    end

    // same-cycle drain and refill of slot 0
    rsp0_ready = 1'b1;
    set0(1'b1, 32'd1, 32'd2, 1'b0);
    set1(1'b0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("dr_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    chk("dr_v0", {31'd0, rsp0_valid}, 32'd1);
    chk("dr_s0", rsp0_sum, 32'd3);

    // fill slot 1 while slot 0 holds, then reset mid-operation
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set0(1'b0, 32'd0, 32'd0, 1'b0);
    set1(1'b1, 32'd4, 32'd4, 1'b0); tick();
    chk("pre_v0", {31'd0, rsp0_valid}, 32'd1);
    chk("pre_s1", rsp1_sum, 32'd8);
    reset = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set0(1'b1, 32'd7, 32'd7, 1'b0);
    set1(1'b1, 32'd9, 32'd9, 1'b0);
    #1;
    chk("mr_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("mr_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("mr_v0", {31'd0, rsp0_valid}, 32'd0);
    chk("mr_v1", {31'd0, rsp1_valid}, 32'd0);
    chk("mr_s0", rsp0_sum, 32'd0);
    chk("mr_s1", rsp1_sum, 32'd0);
    chk("mr_gid", {31'd0, grant_id}, 32'd1);
    reset = 1'b0;
    #1;
    chk("post_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("post_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("post_gid", {31'd0, grant_id}, 32'd0);
    chk("post_s0", rsp0_sum, 32'd14);
    chk("post_v1", {31'd0, rsp1_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
